counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
Sequences an up-counter datapath under command control: start, stop, hold/resume, a programmable terminal count, and one-shot or auto-reload operation. It sits between control logic and the counter, and owns the counter's clear, enable and reload.
The block reports progress as count, busy and a single-cycle done pulse. Downstream logic uses it as a programmable interval timer / event scheduler.

Parameters:
WIDTH, 8, counter and terminal-count width in bits (minimum 2).

Ports:
clock  input  1  single system clock, rising edge.
clear  input  1  asynchronous, active-high reset.
start  input  1  begin a count run; sampled only in IDLE or DONE.
stop  input  1  abort the run; count returns to 0, state goes to IDLE.
hold  input  1  freeze the count while high (RUN/HOLD only).
auto_reload  input  1  1 = wrap to 0 at the terminal count and keep running; 0 = one-shot. Sampled every cycle.
term  input  WIDTH  terminal count; latched into term_q on an accepted start.
count  output  WIDTH  current count value (registered).
busy  output  1  high in RUN or HOLD (decoded from the state register).
done  output  1  registered one-cycle pulse at each terminal-count event.
state  output  2  current FSM state, for debug and visibility.

Behaviour:
- Reset: clear high forces, asynchronously:
  - state = IDLE
  - count = 0, term_q = 0
  - done = 0, busy = 0
  - clear mid-run discards the run; no done pulse is produced.
- State encoding: IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10, DONE = 2'b11.
- Command priority within one cycle: stop > hold > terminal event > increment. start is ignored in RUN and HOLD.
- IDLE:
  - count held at 0.
  - start = 1: at the next edge, term_q <= term and state -> RUN; count stays 0 in that cycle.
- RUN, evaluated at each edge:
  - stop: count <= 0, state -> IDLE.
  - else hold: count frozen, state -> HOLD.
  - else count == term_q (terminal event): done <= 1 for exactly one cycle.
    - auto_reload = 1: count <= 0, remain in RUN.
    - auto_reload = 0: count holds term_q, state -> DONE.
  - else count <= count + 1.
- HOLD:
  - stop: count <= 0, state -> IDLE.
  - hold low: state -> RUN. No increment on the resume edge; counting restarts on the following edge.
- DONE:
  - busy = 0; count stays at term_q.
  - start: term_q <= term, count <= 0, state -> RUN.
  - stop: count <= 0, state -> IDLE.
  - If start and stop are both high, stop wins.
- Latency:
  - Terminal count T, no hold: done is high in cycle T+2 after the start edge.
  - Auto-reload period: T+1 cycles between done pulses.
- Boundaries:
  - term = 0: terminal event occurs on the first RUN edge. With auto_reload = 1, done is high every cycle.
  - term = 2^WIDTH-1: the terminal event fires before overflow. count never wraps through the adder; the only wrap path is the explicit reload to 0.
  - term changes mid-run: no effect until the next accepted start.
  - hold asserted in the same cycle as a terminal match: hold wins; the terminal event fires after resume.
  - done deasserts on the following edge unless a new terminal event occurs.

Decomposition:
- counter_pkg holds:
  - state localparams (IDLE/RUN/HOLD/DONE)
  - DEFAULT_WIDTH = 8
- Natural sub-module: counter_core.
  - Parameterized WIDTH up-counter.
  - Inputs: clock, clear (async), en, zero (synchronous load 0).
  - Output: count.
- counter_sequencer contains the FSM, term_q, the terminal compare, and the done register, and drives en/zero into counter_core.

Test Plan:
- Clock period 10 ns; clear high 0–15 ns -> count = 0, state = IDLE, busy = 0, done = 0 throughout reset.
- term = 5, auto_reload = 0, start pulse -> count 0,0,1,2,3,4,5 then held at 5; done high exactly one cycle; state = DONE; busy = 0.
- term = 3, auto_reload = 1, start -> count 0,1,2,3,0,1,2,3,...; done pulses every 4 cycles; busy stays 1.
- term = 10, hold high for 3 cycles at count = 4 -> count stays 4 for the hold cycles plus the resume cycle, then 5; done is delayed by exactly 4 cycles versus the no-hold case.
- Run with term = 255: stop asserted together with hold at count = 7 -> next edge count = 0, state = IDLE, no done. Restart, then clear pulse at count = 20 -> immediate count = 0, IDLE, no done.
- term = 0, auto_reload = 1 -> done high every cycle. term = 255, one-shot -> count reaches 255 with no wrap; done once; state = DONE. start while RUN is ignored; term changed mid-run is ignored.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared state encoding and default width for the counter sequencer
package counter_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10, DONE = 2'b11} state_t;
endpackage

// File: rtl/counter_core.sv
// counter_core: up-counter with synchronous zero load taking priority over enable
module counter_core #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic             zero,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clock or posedge clear)
    if (clear) count <= '0;
    else if (zero) count <= '0;
    else if (en) count <= count + 1'b1;
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: command FSM driving an up-counter with terminal count, hold and auto-reload
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);
  state_t st, st_n;
  logic [WIDTH-1:0] term_q;
  logic en, zero, load, hit, fire;
  assign hit = count == term_q;
  // terminal event only fires when neither stop nor hold outrank it
  assign fire = st == RUN && !stop && !hold && hit;
  always_comb begin
    st_n = st;
    en = 1'b0;
    zero = 1'b0;
    load = 1'b0;
    case (st)
      IDLE: begin
        st_n = start ? RUN : IDLE;
        load = start;
      end
      RUN: begin
        st_n = stop ? IDLE : hold ? HOLD : (hit && !auto_reload) ? DONE : RUN;
        zero = stop || (fire && auto_reload);
        en = !stop && !hold && !hit;
      end
      HOLD: begin
        st_n = stop ? IDLE : hold ? HOLD : RUN;
        zero = stop;
      end
      DONE: begin
        st_n = stop ? IDLE : start ? RUN : DONE;
        zero = stop || start;
        load = !stop && start;
      end
    endcase
  end
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      st <= IDLE;
      term_q <= '0;
      done <= 1'b0;
    end else begin
      st <= st_n;
      done <= fire;
      if (load) term_q <= term;
    end
  counter_core #(.WIDTH(WIDTH)) u_core (
    .clock(clock),
    .clear(clear),
    .en(en),
    .zero(zero),
    .count(count)
  );
  assign busy = st == RUN || st == HOLD;
  assign state = st;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed and randomized checks of counter_sequencer against a behavioural model
module tb_counter_sequencer;
  logic clock = 1'b0;
  logic clear = 1'b1;
  logic start = 1'b0, stop = 1'b0, hold = 1'b0, auto_reload = 1'b0;
  logic [7:0] term = '0;
  logic [7:0] count;
  logic busy, done;
  logic [1:0] state;
  int checks = 0, failures = 0;
  logic [1:0] m_st;
  logic [7:0] m_cnt, m_tq;
  logic m_dn;

  counter_sequencer #(.WIDTH(8)) dut (
    .clock(clock), .clear(clear), .start(start), .stop(stop), .hold(hold),
    .auto_reload(auto_reload), .term(term), .count(count), .busy(busy),
    .done(done), .state(state)
  );

  always #5 clock = ~clock;

  // reference: 0 idle, 1 counting, 2 paused, 3 finished
  always @(posedge clock or posedge clear)
    if (clear) begin
      m_st <= 2'd0; m_cnt <= 8'd0; m_tq <= 8'd0; m_dn <= 1'b0;
    end else begin
      m_dn <= 1'b0;
      if (m_st == 2'd0) begin
        if (start) begin m_tq <= term; m_st <= 2'd1; end
      end else if (stop) begin
        m_st <= 2'd0; m_cnt <= 8'd0;
      end else if (m_st == 2'd1) begin
        if (hold) m_st <= 2'd2;
        else if (m_cnt == m_tq) begin
          m_dn <= 1'b1;
          if (auto_reload) m_cnt <= 8'd0; else m_st <= 2'd3;
        end else m_cnt <= m_cnt + 8'd1;
      end else if (m_st == 2'd2) begin
        if (!hold) m_st <= 2'd1;
      end else if (start) begin
        m_tq <= term; m_cnt <= 8'd0; m_st <= 2'd1;
      end
    end

  task automatic tick(input logic s, input logic sp, input logic hd, input logic ar, input logic [7:0] t);
    start = s; stop = sp; hold = hd; auto_reload = ar; term = t;
    @(negedge clock);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      #(i == 0 ? 2 : 10);
      checks++;
      if ({state, count, busy, done} !== 12'd0) begin
        failures++;
        $display("FAIL reset t=%0t state=%0d count=%0d busy=%b done=%b required all zero", $time, state, count, busy, done);
      end
    end
    #3 clear = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_oneshot;
    tick(1, 0, 0, 0, 8'd5);
    for (int k = 0; k < 9; k++) begin
      int ec;
      ec = k < 5 ? k : 5;
      checks++;
      if (count !== 8'(ec) || done !== (k == 6)) begin
        failures++;
        $display("FAIL oneshot k=%0d count=%0d done=%b required count=%0d done=%b", k, count, done, ec, k == 6);
      end
      tick(0, 0, 0, 0, 8'd5);
    end
    checks++;
    if (state !== 2'b11 || busy !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_end state=%0d busy=%b required state=3 busy=0", state, busy);
    end
    tick(0, 1, 0, 0, 8'd5);
  endtask

  task automatic test_auto_reload;
    tick(1, 0, 0, 1, 8'd3);
    for (int k = 0; k < 13; k++) begin
      checks++;
      if (count !== 8'(k % 4) || done !== (k > 0 && k % 4 == 0) || busy !== 1'b1) begin
        failures++;
        $display("FAIL auto_reload k=%0d count=%0d done=%b busy=%b required count=%0d done=%b busy=1", k, count, done, busy, k % 4, k > 0 && k % 4 == 0);
      end
      tick(0, 0, 0, 1, 8'd3);
    end
    tick(0, 1, 0, 0, 8'd0);
  endtask

  task automatic test_hold;
    tick(1, 0, 0, 0, 8'd10);
    for (int k = 0; k < 18; k++) begin
      int ec;
      ec = k <= 4 ? k : k <= 8 ? 4 : (k - 4 > 10 ? 10 : k - 4);
      checks++;
      if (count !== 8'(ec) || done !== (k == 15)) begin
        failures++;
        $display("FAIL hold k=%0d count=%0d done=%b required count=%0d done=%b", k, count, done, ec, k == 15);
      end
      tick(0, 0, k >= 4 && k < 7, 0, 8'd10);
    end
    tick(0, 1, 0, 0, 8'd10);
  endtask

  task automatic test_stop_clear;
    tick(1, 0, 0, 0, 8'd255);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (count !== 8'(k) || done !== 1'b0) begin
        failures++;
        $display("FAIL stop_run k=%0d count=%0d done=%b required count=%0d done=0", k, count, done, k);
      end
      tick(0, k == 7, k == 7, 0, 8'd255);
    end
    checks++;
    if (count !== 8'd0 || state !== 2'b00 || done !== 1'b0) begin
      failures++;
      $display("FAIL stop_hold count=%0d state=%0d done=%b required 0 0 0", count, state, done);
    end
    tick(1, 0, 0, 0, 8'd255);
    for (int k = 0; k < 20; k++) tick(0, 0, 0, 0, 8'd255);
    checks++;
    if (count !== 8'd20) begin
      failures++;
      $display("FAIL pre_clear count=%0d required 20", count);
    end
    #2 clear = 1'b1;
    #1;
    checks++;
    if (count !== 8'd0 || state !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_clear count=%0d state=%0d busy=%b done=%b required all zero", count, state, busy, done);
    end
    #1 clear = 1'b0;
    @(negedge clock);
    checks++;
    if (count !== 8'd0 || state !== 2'b00 || done !== 1'b0) begin
      failures++;
      $display("FAIL post_clear count=%0d state=%0d done=%b required all zero", count, state, done);
    end
  endtask

  task automatic test_boundaries;
    int nd;
    tick(1, 0, 0, 1, 8'd0);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (count !== 8'd0 || done !== (k > 0) || state !== 2'b01) begin
        failures++;
        $display("FAIL term0 k=%0d count=%0d done=%b state=%0d required 0 %b 1", k, count, done, state, k > 0);
      end
      tick(0, 0, 0, 1, 8'd0);
    end
    tick(0, 1, 0, 0, 8'd0);
    tick(1, 0, 0, 0, 8'd255);
    nd = 0;
    for (int k = 0; k < 260; k++) begin
      int ec;
      ec = k < 255 ? k : 255;
      nd += int'(done);
      checks++;
      if (count !== 8'(ec) || done !== (k == 256)) begin
        failures++;
        $display("FAIL term255 k=%0d count=%0d done=%b required count=%0d done=%b", k, count, done, ec, k == 256);
      end
      tick(k % 50 == 10, 0, 0, 0, 8'($urandom));
    end
    checks++;
    if (nd !== 1 || state !== 2'b11 || busy !== 1'b0) begin
      failures++;
      $display("FAIL term255_end pulses=%0d state=%0d busy=%b required 1 3 0", nd, state, busy);
    end
    tick(1, 1, 0, 0, 8'd5);
    checks++;
    if (state !== 2'b00 || count !== 8'd0) begin
      failures++;
      $display("FAIL start_stop_done state=%0d count=%0d required 0 0", state, count);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 3000; k++) begin
      checks++;
      if ({state, count, busy, done} !== {m_st, m_cnt, m_st == 2'd1 || m_st == 2'd2, m_dn}) begin
        failures++;
        $display("FAIL random k=%0d state=%0d count=%0d busy=%b done=%b required %0d %0d %b %b", k, state, count, busy, done, m_st, m_cnt, m_st == 2'd1 || m_st == 2'd2, m_dn);
      end
      if ($urandom_range(0, 199) == 0) begin
        clear = 1'b1;
        #1 clear = 1'b0;
      end
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
           1'($urandom), $urandom_range(0, 15) == 0 ? 8'd255 : 8'($urandom_range(0, 12)));
    end
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_auto_reload;
    test_hold;
    test_stop_clear;
    test_boundaries;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
